periph_timer: RTL and testbench

PERIPH_TIMER -- requirements
Module: periph_timer

---
 rtl/periph_timer_pkg.sv | 43 ++++
 rtl/periph_timer.sv | 135 +++++++++++++
 tb/tb_periph_timer.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/periph_timer_pkg.sv
// Shared constants for the timer peripheral: register word offsets inside the
// 24-byte window, TCON bit positions, and the offset-to-register decode.
package periph_timer_pkg;

    localparam logic [31:0] OFF_TH      = 32'h0000_0000;
    localparam logic [31:0] OFF_TL      = 32'h0000_0004;
    localparam logic [31:0] OFF_TCON    = 32'h0000_0008;
    localparam logic [31:0] OFF_LED     = 32'h0000_000C;
    localparam logic [31:0] OFF_DIGITS  = 32'h0000_0010;
    localparam logic [31:0] OFF_SYSTICK = 32'h0000_0014;

    localparam int TCON_EN = 0;  // counter enable
    localparam int TCON_IE = 1;  // interrupt enable
    localparam int TCON_IS = 2;  // interrupt status (sticky)

    localparam logic [31:0] TL_MAX = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        REG_TH      = 3'd0,
        REG_TL      = 3'd1,
        REG_TCON    = 3'd2,
        REG_LED     = 3'd3,
        REG_DIGITS  = 3'd4,
        REG_SYSTICK = 3'd5,
        REG_NONE    = 3'd6
    } reg_sel_e;

    // Map a byte offset from the window base onto a register selector.
    function automatic reg_sel_e decode_offset(input logic [31:0] off);
        reg_sel_e sel;
        case (off)
            OFF_TH:      sel = REG_TH;
            OFF_TL:      sel = REG_TL;
            OFF_TCON:    sel = REG_TCON;
            OFF_LED:     sel = REG_LED;
            OFF_DIGITS:  sel = REG_DIGITS;
            OFF_SYSTICK: sel = REG_SYSTICK;
            default:     sel = REG_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/periph_timer.sv
// Memory-mapped timer peripheral: reloading 32-bit counter with sticky
// interrupt, LED and display registers, and a free-running cycle counter.
module periph_timer
    import periph_timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
    parameter logic [31:0] RESET_TH  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Hit,
    output logic        irq,
    output logic [7:0]  led,
    output logic [11:0] digits
);

    logic [31:0] th_q, th_d;
    logic [31:0] tl_q, tl_d;
    logic [2:0]  tcon_q, tcon_d;
    logic [7:0]  led_q, led_d;
    logic [11:0] digits_q, digits_d;
    logic [31:0] systick_q, systick_d;

    logic [31:0] offset_s;
    reg_sel_e    sel_s;
    logic        wr_s;
    logic        count_s;
    logic        ovf_s;
    logic [31:0] rd_sel_s;

    // Address decode: aligned word inside the window selects a register.
    always_comb begin
        offset_s = Address - BASE_ADDR;
        Hit      = (Address >= BASE_ADDR) && (offset_s <= OFF_SYSTICK) &&
                   (Address[1:0] == 2'b00);
        if (Hit) begin
            sel_s = decode_offset(offset_s);
        end else begin
            sel_s = REG_NONE;
        end
    end

    // Zero-latency load path; zero unless a qualified read hits the window.
    always_comb begin
        case (sel_s)
            REG_TH:      rd_sel_s = th_q;
            REG_TL:      rd_sel_s = tl_q;
            REG_TCON:    rd_sel_s = {29'd0, tcon_q};
            REG_LED:     rd_sel_s = {24'd0, led_q};
            REG_DIGITS:  rd_sel_s = {20'd0, digits_q};
            REG_SYSTICK: rd_sel_s = systick_q;
            default:     rd_sel_s = 32'd0;
        endcase
        if (MemRead && Hit) begin
            ReadData = rd_sel_s;
        end else begin
            ReadData = 32'd0;
        end
    end

    // Next-state: bus writes, counter increment/reload and interrupt status.
    always_comb begin
        th_d      = th_q;
        tl_d      = tl_q;
        tcon_d    = tcon_q;
        led_d     = led_q;
        digits_d  = digits_q;
        systick_d = systick_q + 32'd1;

        wr_s    = MemWrite && Hit;
        // A bus write to TL overrides counting, so no overflow can occur then.
        count_s = tcon_q[TCON_EN] && !(wr_s && (sel_s == REG_TL));
        ovf_s   = count_s && (tl_q == TL_MAX);

        if (wr_s && (sel_s == REG_TL)) begin
            tl_d = WriteData;
        end else if (ovf_s) begin
            tl_d = th_q;  // old TH even if TH is being written this cycle
        end else if (count_s) begin
            tl_d = tl_q + 32'd1;
        end else begin
            tl_d = tl_q;
        end

        if (wr_s && (sel_s == REG_TCON)) begin
            tcon_d[TCON_EN] = WriteData[TCON_EN];
            tcon_d[TCON_IE] = WriteData[TCON_IE];
            tcon_d[TCON_IS] = WriteData[TCON_IS] | (ovf_s & WriteData[TCON_IE]);
        end else if (ovf_s && tcon_q[TCON_IE]) begin
            tcon_d[TCON_IS] = 1'b1;
        end else begin
            tcon_d = tcon_q;
        end

        if (wr_s) begin
            case (sel_s)
                REG_TH:     th_d     = WriteData;
                REG_LED:    led_d    = WriteData[7:0];
                REG_DIGITS: digits_d = WriteData[11:0];
                default:    th_d     = th_q;  // TL/TCON above; SYSTICK is read-only
            endcase
        end else begin
            th_d = th_q;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            th_q      <= RESET_TH;
            tl_q      <= 32'd0;
            tcon_q    <= 3'd0;
            led_q     <= 8'd0;
            digits_q  <= 12'd0;
            systick_q <= 32'd0;
        end else begin
            th_q      <= th_d;
            tl_q      <= tl_d;
            tcon_q    <= tcon_d;
            led_q     <= led_d;
            digits_q  <= digits_d;
            systick_q <= systick_d;
        end
    end

    assign irq    = tcon_q[TCON_IS];
    assign led    = led_q;
    assign digits = digits_q;

endmodule

// File: tb/tb_periph_timer.sv
// Self-checking bench for periph_timer: a register-level model updated on each
// clock edge is compared against the outputs every falling edge, and directed
// scenarios pin the model with hand-computed literals.
module tb_periph_timer;

    localparam logic [31:0] BASE = 32'h4000_0000;
    localparam logic [31:0] A_TH   = 32'h4000_0000;
    localparam logic [31:0] A_TL   = 32'h4000_0004;
    localparam logic [31:0] A_TCON = 32'h4000_0008;
    localparam logic [31:0] A_LED  = 32'h4000_000C;
    localparam logic [31:0] A_DIG  = 32'h4000_0010;
    localparam logic [31:0] A_SYS  = 32'h4000_0014;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        Hit;
    logic        irq;
    logic [7:0]  led;
    logic [11:0] digits;

    int n_checks = 0;
    int n_errs   = 0;

    periph_timer #(.BASE_ADDR(BASE), .RESET_TH(32'h0)) dut (
        .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
        .Address(Address), .WriteData(WriteData), .ReadData(ReadData),
        .Hit(Hit), .irq(irq), .led(led), .digits(digits)
    );

    always #5 clk = ~clk;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_th, m_tl, m_sys;
    logic [2:0]  m_tcon;
    logic [7:0]  m_led;
    logic [11:0] m_dig;
    bit          m_valid = 1'b0;
    logic [31:0] n_th, n_tl;
    logic [2:0]  n_tcon;
    bit          w_hit, roll;
    logic [31:0] w_off;

    function automatic bit m_hit(input logic [31:0] a);
        logic [32:0] lo;
        lo = {1'b0, BASE};
        return (a[1:0] == 2'b00) && ({1'b0, a} >= lo) && ({1'b0, a} <= lo + 33'd20);
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        logic [31:0] r;
        r = 32'd0;
        if (m_hit(a)) begin
            case (a - BASE)
                32'd0:  r = m_th;
                32'd4:  r = m_tl;
                32'd8:  r = {29'd0, m_tcon};
                32'd12: r = {24'd0, m_led};
                32'd16: r = {20'd0, m_dig};
                32'd20: r = m_sys;
                default: r = 32'd0;
            endcase
        end
        return r;
    endfunction

    always @(posedge clk) begin
        if (!reset) begin
            m_th = 32'h0; m_tl = 32'h0; m_tcon = 3'h0;
            m_led = 8'h0; m_dig = 12'h0; m_sys = 32'h0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            w_hit = MemWrite && m_hit(Address);
            w_off = Address - BASE;
            roll  = m_tcon[0] && !(w_hit && w_off == 32'd4) && (m_tl == 32'hFFFF_FFFF);
            n_th  = (w_hit && w_off == 32'd0) ? WriteData : m_th;
            if (w_hit && w_off == 32'd4) n_tl = WriteData;
            else if (roll)               n_tl = m_th;
            else if (m_tcon[0])          n_tl = m_tl + 32'd1;
            else                         n_tl = m_tl;
            if (w_hit && w_off == 32'd8)
                n_tcon = {WriteData[2] | (roll & WriteData[1]), WriteData[1:0]};
            else if (roll && m_tcon[1])
                n_tcon = m_tcon | 3'b100;
            else
                n_tcon = m_tcon;
            if (w_hit && w_off == 32'd12) m_led = WriteData[7:0];
            if (w_hit && w_off == 32'd16) m_dig = WriteData[11:0];
            m_th = n_th; m_tl = n_tl; m_tcon = n_tcon;
            m_sys = m_sys + 32'd1;
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (m_valid) begin
            check32("irq",      {31'd0, irq},    {31'd0, m_tcon[2]});
            check32("led",      {24'd0, led},    {24'd0, m_led});
            check32("digits",   {20'd0, digits}, {20'd0, m_dig});
            check32("hit",      {31'd0, Hit},    {31'd0, m_hit(Address)});
            check32("readdata", ReadData,        MemRead ? m_read(Address) : 32'd0);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        MemWrite  = 1'b1;
        Address   = a;
        WriteData = d;
        tick();
        MemWrite  = 1'b0;
        WriteData = 32'd0;
    endtask

    // Literal read check before the next edge; the read stays up for one cycle.
    task automatic rd_lit(input string name, input logic [31:0] a, input logic [31:0] exp,
                          input logic exp_hit);
        MemRead = 1'b1;
        Address = a;
        #1;
        check32(name, ReadData, exp);
        check32({name, "_hit"}, {31'd0, Hit}, {31'd0, exp_hit});
        tick();
        MemRead = 1'b0;
    endtask

    initial begin
        reset = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
        Address = BASE; WriteData = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        check32("rst_irq", {31'd0, irq}, 32'd0);
        check32("rst_led", {24'd0, led}, 32'd0);
        rd_lit("rst_systick", A_SYS, 32'd0, 1'b1);
        rd_lit("rst_th", A_TH, 32'd0, 1'b1);

        // Overflow reload with interrupt.
        bus_write(A_TH, 32'hFFFF_FFF0);
        bus_write(A_TL, 32'hFFFF_FFFE);
        bus_write(A_TCON, 32'd3);
        rd_lit("tl_pre", A_TL, 32'hFFFF_FFFE, 1'b1);
        check32("irq_pre", {31'd0, irq}, 32'd0);
        rd_lit("tl_max", A_TL, 32'hFFFF_FFFF, 1'b1);
        check32("irq_set", {31'd0, irq}, 32'd1);
        rd_lit("tl_reload", A_TL, 32'hFFFF_FFF0, 1'b1);

        // Clearing the sticky status by rewriting TCON; counting continues.
        bus_write(A_TCON, 32'd3);
        check32("irq_clr", {31'd0, irq}, 32'd0);
        rd_lit("tcon_3", A_TCON, 32'd3, 1'b1);
        rd_lit("tl_run", A_TL, 32'hFFFF_FFF3, 1'b1);

        // TL write beats overflow (interrupt disabled, then enabled).
        bus_write(A_TCON, 32'd0);
        bus_write(A_TL, 32'hFFFF_FFFF);
        bus_write(A_TCON, 32'd1);
        bus_write(A_TL, 32'd5);
        rd_lit("tl_wr_prio", A_TL, 32'd5, 1'b1);
        check32("irq_wr_prio", {31'd0, irq}, 32'd0);
        bus_write(A_TCON, 32'd0);
        bus_write(A_TL, 32'hFFFF_FFFF);
        bus_write(A_TCON, 32'd3);
        bus_write(A_TL, 32'd5);
        check32("irq_wr_prio_ie", {31'd0, irq}, 32'd0);
        rd_lit("tl_wr_prio_ie", A_TL, 32'd5, 1'b1);

        // TCON write coinciding with overflow: status from WriteData[1].
        bus_write(A_TCON, 32'd0);
        bus_write(A_TH, 32'd7);
        bus_write(A_TL, 32'hFFFF_FFFF);
        bus_write(A_TCON, 32'd1);
        bus_write(A_TCON, 32'd2);
        check32("irq_tcon_ovf", {31'd0, irq}, 32'd1);
        rd_lit("tcon_ovf", A_TCON, 32'd6, 1'b1);
        rd_lit("tl_tcon_ovf", A_TL, 32'd7, 1'b1);

        // TH write coinciding with overflow reloads the old TH.
        bus_write(A_TCON, 32'd0);
        bus_write(A_TL, 32'hFFFF_FFFF);
        bus_write(A_TCON, 32'd1);
        bus_write(A_TH, 32'd9);
        rd_lit("tl_old_th", A_TL, 32'd7, 1'b1);
        rd_lit("th_new", A_TH, 32'd9, 1'b1);
        check32("irq_th_ovf", {31'd0, irq}, 32'd0);

        // LED / DIGITS registers and window boundaries.
        bus_write(A_LED, 32'h0000_01A5);
        check32("led_a5", {24'd0, led}, 32'h0000_00A5);
        rd_lit("rd_led", A_LED, 32'h0000_00A5, 1'b1);
        bus_write(A_DIG, 32'hABCD_E5A7);
        check32("digits_5a7", {20'd0, digits}, 32'h0000_05A7);
        rd_lit("rd_dig", A_DIG, 32'h0000_05A7, 1'b1);
        rd_lit("miss_above", 32'h4000_0018, 32'd0, 1'b0);
        rd_lit("miss_unal", 32'h4000_000D, 32'd0, 1'b0);
        rd_lit("miss_below", 32'h3FFF_FFFC, 32'd0, 1'b0);
        bus_write(32'h4000_0018, 32'hFFFF_FFFF);
        bus_write(32'h4000_000E, 32'h0000_0033);
        check32("led_nomiss", {24'd0, led}, 32'h0000_00A5);
        for (int i = 0; i < 4; i++) begin
            bus_write(A_LED, 32'h0000_0100 * i + 32'h0000_0011 * (i + 1));
            rd_lit("led_loop", A_LED, (32'h0000_0011 * (i + 1)) & 32'h0000_00FF, 1'b1);
        end

        // SYSTICK is read-only and counts cycles since reset.
        bus_write(A_SYS, 32'd0);
        rd_lit("systick_ro", A_SYS, m_sys, 1'b1);
        check32("systick_nz", {31'd0, (m_sys > 32'd40)}, 32'd1);

        // Reset in the middle of counting with a pending interrupt and a write.
        bus_write(A_TCON, 32'd3);
        bus_write(A_TL, 32'hFFFF_FFFE);
        tick();
        tick();
        check32("irq_before_rst", {31'd0, irq}, 32'd1);
        reset = 1'b0;
        MemWrite = 1'b1; Address = A_LED; WriteData = 32'h0000_00FF;
        tick();
        reset = 1'b1;
        MemWrite = 1'b0; WriteData = 32'd0;
        check32("mid_rst_irq", {31'd0, irq}, 32'd0);
        check32("mid_rst_led", {24'd0, led}, 32'd0);
        check32("mid_rst_dig", {20'd0, digits}, 32'd0);
        rd_lit("mid_rst_sys", A_SYS, 32'd0, 1'b1);
        rd_lit("mid_rst_tl", A_TL, 32'd0, 1'b1);
        rd_lit("mid_rst_tcon", A_TCON, 32'd0, 1'b1);
        rd_lit("mid_rst_th", A_TH, 32'd0, 1'b1);
        rd_lit("sys_after", A_SYS, 32'd4, 1'b1);

        repeat (2) tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
